alu_sequencer: RTL and testbench
================================

# alu_sequencer

Two-port arbiter and sequencer in front of the shared 32-bit `alu`. It accepts operation requests from two requesters: port 0 is the execute stage and port 1 is the branch/PC unit. It grants one request at a time round-robin, drives the ALU's one-hot control lines and operands, and captures the result and the Z/N flags into a registered response channel with valid/ready backpressure. The block sits between the pipeline control logic and the single combinational ALU instance.

## Interface
- No parameters. Data width is fixed at 32; requester count is fixed at 2.
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1  request present
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle
- `req0_op`, `req1_op`  in  2  opcode: 00 ADD, 01 INC, 10 NEG, 11 SUB
- `req0_a`, `req1_a`, `req0_b`, `req1_b`  in  32  operands
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts response
- `rsp_id`  out  1  requester that issued the response
- `rsp_out`  out  32  result
- `rsp_z`, `rsp_n`  out  1  zero / negative flags of the result
- `alu_a`, `alu_b`  out  32  ALU operands
- `alu_add`, `alu_inc`, `alu_neg`, `alu_sub`  out  1  one-hot ALU controls
- `alu_out`  in  32  ALU result
- `alu_z`, `alu_n`  in  1  ALU flags

## Operation
- ALU semantics, with 32-bit two's-complement wrap and no overflow or carry reporting:
  - ADD: A+B
  - INC: B+1
  - NEG: −A
  - SUB: B−A
- States:
  - IDLE: `reqN_ready` is high for the arbitration winner among valid requesters. On handshake, op/a/b/id are latched and the FSM goes to EXEC.
  - EXEC: one-hot control for the latched op is asserted; `alu_a`/`alu_b` are driven from the latched operands. At the end of the cycle, `alu_out`/`alu_z`/`alu_n` are captured into the `rsp_*` registers, `rsp_valid` is set, and the FSM goes to RESP.
  - RESP: `rsp_*` are held stable until `rsp_valid && rsp_ready`.
    - On that handshake with any `reqN_valid`: the winner's `reqN_ready` is asserted in the same cycle, the new request is latched, and the FSM goes to EXEC.
    - On that handshake with no request: the FSM goes to IDLE.
- Arbitration:
  - A priority pointer starts at 0 after reset.
  - If both requesters are valid, the pointer holder wins; if only one is valid, it wins.
  - After any grant, the pointer moves to the non-granted port.
  - At most one `reqN_ready` is high per cycle, and never outside IDLE or the RESP-handshake cycle.
- Outside EXEC: all four ALU controls are 0 and `alu_a`/`alu_b` are 0.
- `reqN_ready` is combinational from `reqN_valid`, state, pointer and `rsp_ready`. All other outputs are registered or decoded from state.

## Timing
- Reset values:
  - state IDLE; pointer 0
  - `rsp_valid` 0, `rsp_id` 0, `rsp_out` 0, `rsp_z` 0, `rsp_n` 0
  - all `alu_*` outputs 0
  - `req0_ready`/`req1_ready` 0 while `rst` is high
- Latency: a request accepted at edge k is in EXEC during cycle k→k+1, and `rsp_valid` rises after edge k+1.
- Throughput: one operation every 2 cycles when `rsp_ready` is held high.
- Backpressure: while `rsp_valid && !rsp_ready`, `rsp_*` stay constant and both `reqN_ready` stay 0.
- Requesters must hold valid/op/a/b stable until ready; a dropped valid before ready is not recorded.
- Reset asserted in any state returns to IDLE immediately. Any latched op or pending response is discarded; nothing is replayed.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined: adds outputs `flag_z` and `flag_n` (1 bit each). These are sticky flag registers updated only at the end of each EXEC cycle, reset to 0, and held across IDLE/RESP for branch evaluation.
- `ALU_SEQ_FLAGS_EN` undefined: these ports and registers do not exist. Flags are available only via `rsp_z`/`rsp_n` during a response.

## Structure
- Shared package `alu_seq_pkg`:
  - opcode encodings `OP_ADD`, `OP_INC`, `OP_NEG`, `OP_SUB`
  - FSM state encodings `S_IDLE`, `S_EXEC`, `S_RESP`
  - width constant `ALU_W = 32`
- Sub-module `rr_arb2`: two-input round-robin arbiter holding the pointer register. Inputs: `clk`, `rst`, two requests, advance. Outputs: one-hot grant.
- Opcode-to-one-hot decode stays in `alu_sequencer`.

## Test plan
- Port 0 ADD a=5, b=7 with `rsp_ready`=1 → `rsp_out`=12, `rsp_z`=0, `rsp_n`=0, `rsp_id`=0; `rsp_valid` one cycle after acceptance; `alu_add` high only in EXEC.
- Port 1 SUB a=3, b=10, then NEG a=1 → first response 7 (id 1); second response 0xFFFFFFFF with `rsp_n`=1.
- INC b=0xFFFFFFFF → `rsp_out`=0, `rsp_z`=1; with `ALU_SEQ_FLAGS_EN`, `flag_z`=1 persists through the following IDLE cycles.
- Both ports valid continuously from reset → grants alternate 0,1,0,1 and `rsp_id` follows that sequence; never both readies high in one cycle.
- `rsp_ready` low for 3 cycles with port 0 pending → `rsp_*` unchanged, `req0_ready`=0. Then `rsp_ready`=1 → response handshake and new acceptance in the same cycle.
- `rst` pulsed during EXEC, then again while `rsp_valid` is high → all outputs return to reset values immediately and no stale response appears afterward.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU request sequencer.
// Opcode and FSM encodings plus the latched request bundle.
package alu_seq_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_INC = 2'b01,
        OP_NEG = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    typedef struct packed {
        op_t              op;
        logic             id;
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
    } req_t;

endpackage

// File: rtl/alu_sequencer_rr_arb2.sv
// Two-input round-robin arbiter; pointer moves to the
// non-granted port after every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        unique case ({req1, req0})
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Round-robin sequencer in front of the shared 32-bit ALU.
// ALU_SEQ_FLAGS_EN adds sticky flag_z/flag_n outputs.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             flag_z,
    output logic             flag_n,
`endif
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [1:0]       req0_op,
    input  logic [1:0]       req1_op,
    input  logic [ALU_W-1:0] req0_a,
    input  logic [ALU_W-1:0] req1_a,
    input  logic [ALU_W-1:0] req0_b,
    input  logic [ALU_W-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [ALU_W-1:0] rsp_out,
    output logic             rsp_z,
    output logic             rsp_n,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic             alu_add,
    output logic             alu_inc,
    output logic             alu_neg,
    output logic             alu_sub,
    input  logic [ALU_W-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n
);

    state_t     state;
    state_t     state_nxt;
    req_t       lat;
    logic [1:0] grant;
    logic       slot;
    logic       take;

    // A new request may enter in IDLE or in the cycle the
    // pending response is consumed.
    assign slot = !rst && ((state == S_IDLE) ||
                  (state == S_RESP && rsp_ready));

    assign req0_ready = slot && grant[0];
    assign req1_ready = slot && grant[1];
    assign take       = req0_ready || req1_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0_valid),
        .req1    (req1_valid),
        .advance (take),
        .grant   (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (take) state_nxt = S_EXEC;
            end
            S_EXEC: state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = take ? S_EXEC : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_add = 1'b0;
        alu_inc = 1'b0;
        alu_neg = 1'b0;
        alu_sub = 1'b0;
        if (state == S_EXEC) begin
            alu_a = lat.a;
            alu_b = lat.b;
            unique case (lat.op)
                OP_ADD: alu_add = 1'b1;
                OP_INC: alu_inc = 1'b1;
                OP_NEG: alu_neg = 1'b1;
                OP_SUB: alu_sub = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat <= '0;
        end else if (take) begin
            if (req1_ready) begin
                lat.op <= op_t'(req1_op);
                lat.id <= 1'b1;
                lat.a  <= req1_a;
                lat.b  <= req1_b;
            end else begin
                lat.op <= op_t'(req0_op);
                lat.id <= 1'b0;
                lat.a  <= req0_a;
                lat.b  <= req0_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_out   <= '0;
            rsp_z     <= 1'b0;
            rsp_n     <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= lat.id;
            rsp_out   <= alu_out;
            rsp_z     <= alu_z;
            rsp_n     <= alu_n;
        end else if (state == S_RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Sticky copies kept for branch evaluation between ops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (state == S_EXEC) begin
            flag_z <= alu_z;
            flag_n <= alu_n;
        end
    end
`else
    // Flags are visible only through rsp_z/rsp_n.
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU.
// Covers ADD/SUB/NEG/INC, round-robin, backpressure, reset.
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_out;
    logic        rsp_z, rsp_n;
    logic [31:0] alu_a, alu_b, alu_out;
    logic        alu_add, alu_inc, alu_neg, alu_sub;
    logic        alu_z, alu_n;
`ifdef ALU_SEQ_FLAGS_EN
    logic        flag_z, flag_n;
`endif

    int vectors = 0;
    int miscompares = 0;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ALU_SEQ_FLAGS_EN
        .flag_z     (flag_z),
        .flag_n     (flag_n),
`endif
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req1_a     (req1_a),
        .req0_b     (req0_b),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .rsp_z      (rsp_z),
        .rsp_n      (rsp_n),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_add    (alu_add),
        .alu_inc    (alu_inc),
        .alu_neg    (alu_neg),
        .alu_sub    (alu_sub),
        .alu_out    (alu_out),
        .alu_z      (alu_z),
        .alu_n      (alu_n)
    );

    // Stand-in for the shared combinational ALU.
    always_comb begin
        alu_out = 32'd0;
        if (alu_add)      alu_out = alu_a + alu_b;
        else if (alu_inc) alu_out = alu_b + 32'd1;
        else if (alu_neg) alu_out = 32'd0 - alu_a;
        else if (alu_sub) alu_out = alu_b - alu_a;
    end
    assign alu_z = (alu_out == 32'd0);
    assign alu_n = alu_out[31];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_op    = 2'b00;
        req1_op    = 2'b00;
        req0_a     = 32'd0;
        req0_b     = 32'd0;
        req1_a     = 32'd0;
        req1_b     = 32'd0;
        rsp_ready  = 1'b0;
        #2;
        chk("rst_req0_ready", req0_ready, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 32'd0);
        chk("rst_rsp_out", rsp_out, 32'd0);
        chk("rst_rsp_id", rsp_id, 32'd0);
        chk("rst_alu_add", alu_add, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        req0_valid = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Port 0 ADD 5+7
        req0_valid = 1'b1;
        req0_op = 2'b00; req0_a = 32'd5; req0_b = 32'd7;
        rsp_ready = 1'b1;
        #1;
        chk("t1_ready0", req0_ready, 32'd1);
        chk("t1_ready1", req1_ready, 32'd0);
        chk("t1_idle_add", alu_add, 32'd0);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t1_exec_add", alu_add, 32'd1);
        chk("t1_exec_a", alu_a, 32'd5);
        chk("t1_exec_b", alu_b, 32'd7);
        chk("t1_exec_rspv", rsp_valid, 32'd0);
        chk("t1_exec_ready0", req0_ready, 32'd0);
        step();
        chk("t1_rsp_valid", rsp_valid, 32'd1);
        chk("t1_rsp_out", rsp_out, 32'd12);
        chk("t1_rsp_z", rsp_z, 32'd0);
        chk("t1_rsp_n", rsp_n, 32'd0);
        chk("t1_rsp_id", rsp_id, 32'd0);
        chk("t1_resp_add", alu_add, 32'd0);
        step();
        chk("t1_done_valid", rsp_valid, 32'd0);

        // Port 1 SUB 10-3, then NEG 1
        req1_valid = 1'b1;
        req1_op = 2'b11; req1_a = 32'd3; req1_b = 32'd10;
        #1;
        chk("t2_ready1", req1_ready, 32'd1);
        chk("t2_ready0", req0_ready, 32'd0);
        step();
        req1_op = 2'b10; req1_a = 32'd1; req1_b = 32'd0;
        #1;
        chk("t2_exec_sub", alu_sub, 32'd1);
        chk("t2_exec_a", alu_a, 32'd3);
        chk("t2_exec_b", alu_b, 32'd10);
        chk("t2_exec_ready1", req1_ready, 32'd0);
        step();
        chk("t2_rsp_out", rsp_out, 32'd7);
        chk("t2_rsp_id", rsp_id, 32'd1);
        chk("t2_rsp_valid", rsp_valid, 32'd1);
        chk("t2_hs_ready1", req1_ready, 32'd1);
        step();
        req1_valid = 1'b0;
        #1;
        chk("t2_exec_neg", alu_neg, 32'd1);
        chk("t2_exec_neg_a", alu_a, 32'd1);
        chk("t2_exec2_rspv", rsp_valid, 32'd0);
        step();
        chk("t2_neg_out", rsp_out, 32'hFFFF_FFFF);
        chk("t2_neg_n", rsp_n, 32'd1);
        chk("t2_neg_z", rsp_z, 32'd0);
        chk("t2_neg_id", rsp_id, 32'd1);
        step();

        // INC wraps to zero
        req0_valid = 1'b1;
        req0_op = 2'b01; req0_a = 32'd0; req0_b = 32'hFFFF_FFFF;
        #1;
        chk("t3_ready0", req0_ready, 32'd1);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t3_exec_inc", alu_inc, 32'd1);
        chk("t3_exec_b", alu_b, 32'hFFFF_FFFF);
        step();
        chk("t3_rsp_out", rsp_out, 32'd0);
        chk("t3_rsp_z", rsp_z, 32'd1);
        chk("t3_rsp_n", rsp_n, 32'd0);
        step();
        chk("t3_idle_valid", rsp_valid, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("t3_flag_z_idle0", flag_z, 32'd1);
        step();
        chk("t3_flag_z_idle1", flag_z, 32'd1);
        chk("t3_flag_n_idle1", flag_n, 32'd0);
`endif

        // Both valid from reset: grants alternate
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_op = 2'b00; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1;
        req1_op = 2'b00; req1_a = 32'd2; req1_b = 32'd2;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic odd;
            odd = (i % 2) == 1;
            chk($sformatf("t4_ready0_%0d", i), req0_ready, {31'd0, !odd});
            chk($sformatf("t4_ready1_%0d", i), req1_ready, {31'd0, odd});
            step();
            chk($sformatf("t4_exec_r0_%0d", i), req0_ready, 32'd0);
            chk($sformatf("t4_exec_r1_%0d", i), req1_ready, 32'd0);
            step();
            chk($sformatf("t4_rsp_valid_%0d", i), rsp_valid, 32'd1);
            chk($sformatf("t4_rsp_id_%0d", i), rsp_id, {31'd0, odd});
            chk($sformatf("t4_rsp_out_%0d", i), rsp_out,
                odd ? 32'd4 : 32'd2);
        end

        // Backpressure with port 0 pending
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        req0_op = 2'b11; req0_a = 32'd4; req0_b = 32'd9;
        #1;
        chk("t5_hold_ready0", req0_ready, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t5_out_%0d", i), rsp_out, 32'd4);
            chk($sformatf("t5_id_%0d", i), rsp_id, 32'd1);
            chk($sformatf("t5_valid_%0d", i), rsp_valid, 32'd1);
            chk($sformatf("t5_ready0_%0d", i), req0_ready, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("t5_hs_ready0", req0_ready, 32'd1);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t5_exec_sub", alu_sub, 32'd1);
        chk("t5_exec_a", alu_a, 32'd4);
        chk("t5_exec_rspv", rsp_valid, 32'd0);
        step();
        chk("t5_rsp_out", rsp_out, 32'd5);
        chk("t5_rsp_id", rsp_id, 32'd0);
        step();
        chk("t5_done_valid", rsp_valid, 32'd0);

        // Reset during EXEC
        req1_valid = 1'b1;
        req1_op = 2'b00; req1_a = 32'd100; req1_b = 32'd1;
        #1;
        chk("t6_ready1", req1_ready, 32'd1);
        step();
        req1_valid = 1'b0;
        #1;
        chk("t6_exec_add", alu_add, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_add", alu_add, 32'd0);
        chk("t6_rst_a", alu_a, 32'd0);
        chk("t6_rst_valid", rsp_valid, 32'd0);
        chk("t6_rst_out", rsp_out, 32'd0);
        rst = 1'b0;
        step();
        chk("t6_post_valid0", rsp_valid, 32'd0);
        step();
        chk("t6_post_valid1", rsp_valid, 32'd0);
        chk("t6_post_out", rsp_out, 32'd0);

        // Reset while a response is held
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        req0_op = 2'b10; req0_a = 32'd2; req0_b = 32'd0;
        #1;
        chk("t6b_ready0", req0_ready, 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        chk("t6b_valid", rsp_valid, 32'd1);
        chk("t6b_out", rsp_out, 32'hFFFF_FFFE);
        chk("t6b_n", rsp_n, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6b_rst_valid", rsp_valid, 32'd0);
        chk("t6b_rst_out", rsp_out, 32'd0);
        chk("t6b_rst_n", rsp_n, 32'd0);
        chk("t6b_rst_id", rsp_id, 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        step();
        step();
        chk("t6b_post_valid", rsp_valid, 32'd0);
        chk("t6b_post_ready0", req0_ready, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
